ft6206_touch_target: RTL
========================

Name: ft6206_touch_target

Overview:
- I2C responder (target) that emulates the FT6206 capacitive-touch controller register file.
- Lets `ft6206_controller` (the I2C initiator) be exercised in simulation and on hardware loopback without a real panel.
- Touch points come from the parallel inputs; the block serves them over SCL/SDA with the FT6206 register layout.
- Sits beside `ft6206_controller` on the same `scl`/`sda` nets; its open-drain output is resolved by a pull-up.

Parameters:
- I2C_ADDR, 7'h38, 7-bit target address the block responds to.
- SYNC_STAGES, 2, flip-flop stages on `scl_i`/`sda_i` before edge detection (minimum 2).
- CHIP_ID, 8'h06, value returned at register 0xA3.
- VENDOR_ID, 8'h11, value returned at register 0xA8.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL level from the bus (asynchronous).
- sda_i  in  1  SDA level from the bus (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release the line.
- t0_valid  in  1  touch point 0 present.
- t0_x  in  12  touch 0 X coordinate.
- t0_y  in  12  touch 0 Y coordinate.
- t1_valid  in  1  touch point 1 present.
- t1_x  in  12  touch 1 X coordinate.
- t1_y  in  12  touch 1 Y coordinate.
- busy  out  1  high from an address match until STOP or a NACKed/mismatched transaction ends.
- reg_ptr  out  8  current register pointer (debug).

Behaviour:
- Reset values: sda_oe=0, busy=0, reg_ptr=0, state=IDLE, snapshot cleared.
- Input conditioning:
  - scl_i/sda_i pass through SYNC_STAGES flops; one further flop provides the previous value for edge detection.
  - SCL rise/fall, START (SDA falls while SCL high) and STOP (SDA rises while SCL high) are single-cycle events.
- Bus timing:
  - Data bits are sampled on SCL rise.
  - sda_oe changes only on the cycle of a detected SCL fall, i.e. SYNC_STAGES+1 clk after the pin edge.
  - The bus requires SCL low ≥ SYNC_STAGES+4 clk.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
- START (including repeated START) in any state:
  - Enter ADDR, bit counter=0, sda_oe=0.
  - reg_ptr is retained.
- STOP in any state: enter IDLE, sda_oe=0, busy=0.
- ADDR:
  - Shift 8 bits MSB first.
  - On the 8th rise, if addr[7:1]==I2C_ADDR then go to ADDR_ACK and set busy. Otherwise go to WAIT_STOP and never drive SDA.
- ADDR_ACK:
  - On the next SCL fall, sda_oe=1. On the following fall, sda_oe=0.
  - R/W=0: go to REG.
  - R/W=1: capture the touch snapshot and go to RDATA, driving the first bit on that same fall.
- REG: receive 8 bits; they load reg_ptr. ACK exactly as in ADDR_ACK, then go to WDATA.
- WDATA:
  - Bytes are ACKed and discarded; all registers are read-only.
  - reg_ptr increments per byte.
- RDATA:
  - Shift register loaded with map(reg_ptr) from the snapshot.
  - sda_oe = ~bit, updated on each SCL fall, MSB first.
  - After the 8th bit's fall, release SDA and go to RACK; reg_ptr increments (8-bit wrap, 0xFF→0x00).
- RACK: sample SDA on rise.
  - 0 = master ACK: load next byte and go to RDATA.
  - 1 = master NACK: go to WAIT_STOP, SDA released.
- Snapshot:
  - All t0_*/t1_* inputs are latched once per read transaction, at the address ACK.
  - Multi-byte reads are coherent even if the inputs change mid-read.
- Register map (unlisted addresses read 0x00):
  - 0x00 DEV_MODE: 0x00.
  - 0x02 TD_STATUS: {6'b0, count}, count = t0_valid+t1_valid.
  - 0x03: {t0_valid?2'b10:2'b11, 2'b00, x0[11:8]}.
  - 0x04: x0[7:0].
  - 0x05: {4'h0, y0[11:8]}.
  - 0x06: y0[7:0].
  - 0x09: {t1_valid?2'b10:2'b11, 2'b00, x1[11:8]}.
  - 0x0A: x1[7:0].
  - 0x0B: {4'h1, y1[11:8]}.
  - 0x0C: y1[7:0].
  - 0xA3: CHIP_ID.
  - 0xA8: VENDOR_ID.
- Reset asserted mid-transaction: the block returns to the reset values on the next clk, SDA is released immediately, and it ignores the bus until the next START.

Test Plan:
- Register read: t0 valid at (120,200), t1 invalid; write 0x70 then reg 0x02, repeated START, read 0x71 for 5 bytes, master NACKs the last, then STOP -> data 0x01,0x80,0x78,0x00,0xC8; ACK driven low on the address and register bytes; busy falls at STOP; reg_ptr=0x07.
- Address mismatch: transaction to 0x72 -> sda_oe stays 0 for the whole transaction, busy stays 0, reg_ptr unchanged.
- ID registers: set ptr 0xA3 and read 1 byte -> 0x06; set ptr 0xA8 and read 1 byte -> 0x11; unmapped 0x50 -> 0x00.
- Coherent snapshot: read from 0x03; change t0_x from 0x178 to 0x005 after the first byte -> bytes are 0x81,0x78.
- Pointer wrap: set ptr 0xFF and read 2 bytes -> 0x00 then DEV_MODE 0x00; reg_ptr=0x01.
- Reset mid-read: assert rst while sda_oe=1 in RDATA -> sda_oe=0 on the next clk; the next full transaction reads correctly.

Source files
------------

// File: rtl/ft6206_touch_target.sv
// FT6206 register-file emulator: an I2C target that serves two parallel touch
// points through the FT6206 register layout on an open-drain SDA line.
module ft6206_touch_target #(
  parameter logic [6:0]  I2C_ADDR    = 7'h38,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CHIP_ID     = 8'h06,
  parameter logic [7:0]  VENDOR_ID   = 8'h11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic        t0_valid,
  input  logic [11:0] t0_x,
  input  logic [11:0] t0_y,
  input  logic        t1_valid,
  input  logic [11:0] t1_x,
  input  logic [11:0] t1_y,
  output logic        busy,
  output logic [7:0]  reg_ptr
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StReg, StRegAck,
    StWdata, StWdataAck, StRdata, StRack, StWaitStop
  } state_e;

  typedef struct packed {
    logic        v0;
    logic [11:0] x0;
    logic [11:0] y0;
    logic        v1;
    logic [11:0] x1;
    logic [11:0] y1;
  } snap_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_ev, stop_ev;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  snap_t       snap_q, snap_d;
  snap_t       live;
  logic [7:0]  first_byte;

  // Register map decode; unlisted addresses read as zero.
  function automatic logic [7:0] reg_map(input logic [7:0] ptr, input snap_t s);
    logic [1:0] count;
    count = {1'b0, s.v0} + {1'b0, s.v1};
    case (ptr)
      8'h02:   reg_map = {6'b0, count};
      8'h03:   reg_map = {(s.v0 ? 2'b10 : 2'b11), 2'b00, s.x0[11:8]};
      8'h04:   reg_map = s.x0[7:0];
      8'h05:   reg_map = {4'h0, s.y0[11:8]};
      8'h06:   reg_map = s.y0[7:0];
      8'h09:   reg_map = {(s.v1 ? 2'b10 : 2'b11), 2'b00, s.x1[11:8]};
      8'h0A:   reg_map = s.x1[7:0];
      8'h0B:   reg_map = {4'h1, s.y1[11:8]};
      8'h0C:   reg_map = s.y1[7:0];
      8'hA3:   reg_map = CHIP_ID;
      8'hA8:   reg_map = VENDOR_ID;
      default: reg_map = 8'h00;
    endcase
  endfunction

  // Synchronise SCL/SDA and keep one extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;
  assign start_ev = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_ev  = scl_s & scl_prev & ~sda_prev & sda_s;

  assign live       = '{v0: t0_valid, x0: t0_x, y0: t0_y, v1: t1_valid, x1: t1_x, y1: t1_y};
  assign first_byte = reg_map(ptr_q, live);

  // Protocol state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      ptr_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      ack_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      ack_q   <= ack_d;
      snap_q  <= snap_d;
    end
  end

  // Next-state logic; SDA drive only ever changes on a detected SCL fall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    ack_d   = ack_q;
    snap_d  = snap_q;
    if (start_ev) begin
      state_d = StAddr;
      cnt_d   = '0;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
    end else if (stop_ev) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      ack_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: ;
        StAddr: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (shreg_q[6:0] == I2C_ADDR) begin
                rw_d    = sda_s;
                busy_d  = 1'b1;
                ack_d   = 1'b0;
                state_d = StAddrAck;
              end else begin
                busy_d  = 1'b0;
                state_d = StWaitStop;
              end
            end
          end
        end
        StReg, StWdata: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              ack_d = 1'b0;
              if (state_q == StReg) begin
                ptr_d   = {shreg_q[6:0], sda_s};
                state_d = StRegAck;
              end else begin
                ptr_d   = ptr_q + 8'd1;
                state_d = StWdataAck;
              end
            end
          end
        end
        StAddrAck, StRegAck, StWdataAck: begin
          // First fall asserts ACK, second fall ends the ACK slot.
          if (scl_fall) begin
            if (!ack_q) begin
              oe_d  = 1'b1;
              ack_d = 1'b1;
            end else begin
              ack_d = 1'b0;
              cnt_d = '0;
              if (state_q == StAddrAck && rw_q) begin
                snap_d  = live;
                oe_d    = ~first_byte[7];
                shreg_d = {first_byte[6:0], 1'b0};
                cnt_d   = 4'd1;
                state_d = StRdata;
              end else begin
                oe_d    = 1'b0;
                state_d = (state_q == StAddrAck) ? StReg : StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              ptr_d   = ptr_q + 8'd1;
              state_d = StRack;
            end else begin
              oe_d    = ~shreg_q[7];
              shreg_d = {shreg_q[6:0], 1'b0};
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        StRack: begin
          if (scl_rise) begin
            if (!sda_s) begin
              shreg_d = reg_map(ptr_q, snap_q);
              cnt_d   = '0;
              state_d = StRdata;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign sda_oe  = oe_q;
  assign busy    = busy_q;
  assign reg_ptr = ptr_q;

endmodule
